// File: rtl/vlsu_addr_gen_if.sv
// Bundle of command, store-stream and memory-queue request signals for vlsu_addr_gen.
// The master modport is the address generator; the slave modport is its environment.
interface vlsu_addr_gen_if #(
    parameter int unsigned MBUS_ADDR_WIDTH = 32,
    parameter int unsigned RVV_DATA_WIDTH  = 64,
    parameter int unsigned RVV_DW_B        = RVV_DATA_WIDTH >> 3,
    parameter int unsigned FIFO_DEPTH_BITS = 9
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_is_store;
    logic [MBUS_ADDR_WIDTH-1:0] cmd_base;
    logic [MBUS_ADDR_WIDTH-1:0] cmd_stride;
    logic [FIFO_DEPTH_BITS-1:0] cmd_count;
    logic [RVV_DATA_WIDTH-1:0]  st_data;
    logic [RVV_DW_B-1:0]        st_be;
    logic                       st_valid;
    logic                       st_ready;
    logic                       rvv_req_out;
    logic                       rvv_valid_out;
    logic [MBUS_ADDR_WIDTH-1:0] rvv_addr_out;
    logic [RVV_DATA_WIDTH-1:0]  rvv_data_out;
    logic [RVV_DW_B-1:0]        rvv_be_out;
    logic                       rvv_start_out;
    logic                       rvv_ready_out;
    logic                       rvv_done_ld;
    logic                       rvv_done_st;
    logic                       cmd_done;
    logic                       cmd_err;

    modport master (
        input  cmd_valid, cmd_is_store, cmd_base, cmd_stride, cmd_count,
        input  st_data, st_be, st_valid, rvv_done_ld, rvv_done_st,
        output cmd_ready, st_ready, rvv_req_out, rvv_valid_out, rvv_addr_out,
        output rvv_data_out, rvv_be_out, rvv_start_out, rvv_ready_out, cmd_done, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_is_store, cmd_base, cmd_stride, cmd_count,
        output st_data, st_be, st_valid, rvv_done_ld, rvv_done_st,
        input  cmd_ready, st_ready, rvv_req_out, rvv_valid_out, rvv_addr_out,
        input  rvv_data_out, rvv_be_out, rvv_start_out, rvv_ready_out, cmd_done, cmd_err
    );
endinterface

// File: rtl/vlsu_addr_gen.sv
// Vector load/store address generator: expands one strided command into per-beat requests.
// Define VLSU_ALIGN_CHECK_EN to reject commands with misaligned base/stride via cmd_err.
module vlsu_addr_gen #(
    parameter int unsigned MBUS_ADDR_WIDTH = 32,
    parameter int unsigned MBUS_DATA_WIDTH = 32,
    parameter int unsigned MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
    parameter int unsigned RVV_DATA_WIDTH  = 64,
    parameter int unsigned RVV_DW_B        = RVV_DATA_WIDTH >> 3,
    parameter int unsigned FIFO_DEPTH_BITS = 9
) (
    input logic             clk,
    input logic             rst,
    vlsu_addr_gen_if.master bus
);
    typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, ST_WAIT} state_e;

    localparam logic [FIFO_DEPTH_BITS-1:0] CNT_ONE = FIFO_DEPTH_BITS'(1);

    state_e                     state_q, state_d;
    logic [FIFO_DEPTH_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic [FIFO_DEPTH_BITS-1:0] count_q, count_d;
    logic [MBUS_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [MBUS_ADDR_WIDTH-1:0] stride_q, stride_d;
    logic                       req_q, req_d;
    logic                       valid_q, valid_d;
    logic [MBUS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [RVV_DATA_WIDTH-1:0]  data_q, data_d;
    logic [RVV_DW_B-1:0]        be_q, be_d;
    logic                       start_q, start_d;
    logic                       ready_out_q, ready_out_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       st_ready_q, st_ready_d;
    logic                       cmd_done_q, cmd_done_d;
    logic                       last_beat;

`ifdef VLSU_ALIGN_CHECK_EN
    localparam int unsigned ALIGN_BITS = $clog2(MBUS_DW_B);
    logic cmd_err_q, cmd_err_d;
    logic misaligned;
    assign misaligned = (bus.cmd_base[ALIGN_BITS-1:0] != '0) ||
                        (bus.cmd_stride[ALIGN_BITS-1:0] != '0);
`endif

    assign last_beat = (beat_cnt_q == count_q - CNT_ONE);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        count_d    = count_q;
        cur_addr_d = cur_addr_q;
        stride_d   = stride_q;
        req_d      = 1'b0;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        cmd_done_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
`ifdef VLSU_ALIGN_CHECK_EN
        cmd_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    stride_d = bus.cmd_stride;
                    count_d  = bus.cmd_count;
                    if (bus.cmd_count == '0) begin
                        cmd_done_d = 1'b1;
`ifdef VLSU_ALIGN_CHECK_EN
                    end else if (misaligned) begin
                        cmd_err_d = 1'b1;
`endif
                    end else if (bus.cmd_is_store) begin
                        beat_cnt_d = '0;
                        cur_addr_d = bus.cmd_base;
                        state_d    = ST_ISSUE;
                    end else begin
                        // Load beat 0 goes out on the accepting edge itself.
                        req_d      = 1'b1;
                        start_d    = 1'b1;
                        addr_d     = bus.cmd_base;
                        beat_cnt_d = CNT_ONE;
                        cur_addr_d = bus.cmd_base + bus.cmd_stride;
                        state_d    = (bus.cmd_count == CNT_ONE) ? LD_WAIT : LD_ISSUE;
                    end
                end
            end
            LD_ISSUE: begin
                req_d      = 1'b1;
                addr_d     = cur_addr_q;
                beat_cnt_d = beat_cnt_q + CNT_ONE;
                cur_addr_d = cur_addr_q + stride_q;
                if (last_beat) state_d = LD_WAIT;
            end
            LD_WAIT: begin
                if (bus.rvv_done_ld) begin
                    cmd_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.st_valid) begin
                    valid_d    = 1'b1;
                    start_d    = (beat_cnt_q == '0);
                    addr_d     = cur_addr_q;
                    data_d     = bus.st_data;
                    be_d       = bus.st_be;
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    cur_addr_d = cur_addr_q + stride_q;
                    if (last_beat) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.rvv_done_st) begin
                    cmd_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        st_ready_d  = (state_d == ST_ISSUE);
        // Lags LD_WAIT entry by one cycle so it never coincides with the last request.
        ready_out_d = (state_q == LD_WAIT) && (state_d == LD_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            count_q     <= '0;
            cur_addr_q  <= '0;
            stride_q    <= '0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            be_q        <= '0;
            start_q     <= 1'b0;
            ready_out_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            st_ready_q  <= 1'b0;
            cmd_done_q  <= 1'b0;
`ifdef VLSU_ALIGN_CHECK_EN
            cmd_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            count_q     <= count_d;
            cur_addr_q  <= cur_addr_d;
            stride_q    <= stride_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            be_q        <= be_d;
            start_q     <= start_d;
            ready_out_q <= ready_out_d;
            cmd_ready_q <= cmd_ready_d;
            st_ready_q  <= st_ready_d;
            cmd_done_q  <= cmd_done_d;
`ifdef VLSU_ALIGN_CHECK_EN
            cmd_err_q   <= cmd_err_d;
`endif
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.st_ready      = st_ready_q;
    assign bus.rvv_req_out   = req_q;
    assign bus.rvv_valid_out = valid_q;
    assign bus.rvv_addr_out  = addr_q;
    assign bus.rvv_data_out  = data_q;
    assign bus.rvv_be_out    = be_q;
    assign bus.rvv_start_out = start_q;
    assign bus.rvv_ready_out = ready_out_q;
    assign bus.cmd_done      = cmd_done_q;
`ifdef VLSU_ALIGN_CHECK_EN
    assign bus.cmd_err       = cmd_err_q;
`else
    assign bus.cmd_err       = 1'b0;
`endif
endmodule

// File: tb/tb_vlsu_addr_gen.sv
// Directed self-checking bench for vlsu_addr_gen: loads, stores, zero count, wrap,
// mid-command reset and misaligned base (honours VLSU_ALIGN_CHECK_EN if defined).
module tb_vlsu_addr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    vlsu_addr_gen_if #(
        .MBUS_ADDR_WIDTH(32),
        .RVV_DATA_WIDTH (64),
        .RVV_DW_B       (8),
        .FIFO_DEPTH_BITS(9)
    ) bus ();

    vlsu_addr_gen #(
        .MBUS_ADDR_WIDTH(32),
        .MBUS_DATA_WIDTH(32),
        .MBUS_DW_B      (4),
        .RVV_DATA_WIDTH (64),
        .RVV_DW_B       (8),
        .FIFO_DEPTH_BITS(9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic st, input logic [31:0] base,
                            input logic [31:0] stride, input logic [8:0] cnt);
        bus.cmd_valid    = 1'b1;
        bus.cmd_is_store = st;
        bus.cmd_base     = base;
        bus.cmd_stride   = stride;
        bus.cmd_count    = cnt;
    endtask

    // Store pattern: st_valid per step, and which beat (if any) each step emits.
    logic        st_pat  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] st_addr [4] = '{32'h0000_2000, 32'h0000_1FF8, 32'h0000_1FF0, 32'h0000_1FE8};

    initial begin
        int unsigned beat;
        logic [63:0] exp_data;
        logic [7:0]  exp_be;

        bus.cmd_valid    = 1'b0;
        bus.cmd_is_store = 1'b0;
        bus.cmd_base     = '0;
        bus.cmd_stride   = '0;
        bus.cmd_count    = '0;
        bus.st_data      = '0;
        bus.st_be        = '0;
        bus.st_valid     = 1'b0;
        bus.rvv_done_ld  = 1'b0;
        bus.rvv_done_st  = 1'b0;
        exp_data         = '0;
        exp_be           = '0;

        tick();
        tick();
        chk1 ("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk1 ("rst_st_ready",  bus.st_ready, 1'b0);
        chk1 ("rst_req",       bus.rvv_req_out, 1'b0);
        chk1 ("rst_valid",     bus.rvv_valid_out, 1'b0);
        chk32("rst_addr",      bus.rvv_addr_out, 32'h0);
        chk64("rst_data",      bus.rvv_data_out, 64'h0);
        chk1 ("rst_start",     bus.rvv_start_out, 1'b0);
        chk1 ("rst_ready_out", bus.rvv_ready_out, 1'b0);
        chk1 ("rst_done",      bus.cmd_done, 1'b0);
        chk1 ("rst_err",       bus.cmd_err, 1'b0);
        rst = 1'b0;

        // Unit-stride load of 8 beats
        send_cmd(1'b0, 32'h0000_1000, 32'd4, 9'd8);
        tick();
        bus.cmd_valid = 1'b0;
        chk1 ("ld_cmd_ready_busy", bus.cmd_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            chk1 ("ld_req",       bus.rvv_req_out, 1'b1);
            chk32("ld_addr",      bus.rvv_addr_out, 32'h0000_1000 + 32'(4 * i));
            chk1 ("ld_start",     bus.rvv_start_out, i == 0);
            chk1 ("ld_ready_out_early", bus.rvv_ready_out, 1'b0);
        end
        tick();
        chk1("ld_req_end",      bus.rvv_req_out, 1'b0);
        chk1("ld_ready_out",    bus.rvv_ready_out, 1'b1);
        bus.rvv_done_st = 1'b1;
        tick();
        bus.rvv_done_st = 1'b0;
        chk1("ld_wrong_done",   bus.cmd_done, 1'b0);
        bus.rvv_done_ld = 1'b1;
        tick();
        bus.rvv_done_ld = 1'b0;
        chk1("ld_cmd_done",     bus.cmd_done, 1'b1);
        chk1("ld_cmd_ready",    bus.cmd_ready, 1'b1);
        chk1("ld_ready_out_off", bus.rvv_ready_out, 0);

        // Zero-count command accepted on the first cycle back in IDLE
        send_cmd(1'b0, 32'h0000_4000, 32'd4, 9'd0);
        tick();
        bus.cmd_valid = 1'b0;
        chk1("z_cmd_done",  bus.cmd_done, 1'b1);
        chk1("z_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("z_req",       bus.rvv_req_out, 1'b0);
        chk1("z_valid",     bus.rvv_valid_out, 1'b0);
        tick();
        chk1("z_done_once", bus.cmd_done, 1'b0);
        chk1("z_req2",      bus.rvv_req_out, 1'b0);

        // Negative-stride store with gaps in st_valid
        send_cmd(1'b1, 32'h0000_2000, 32'hFFFF_FFF8, 9'd4);
        tick();
        bus.cmd_valid = 1'b0;
        chk1("st_cmd_ready", bus.cmd_ready, 1'b0);
        chk1("st_ready_on",  bus.st_ready, 1'b1);
        chk1("st_no_beat",   bus.rvv_valid_out, 1'b0);
        beat = 0;
        for (int s = 0; s < 6; s++) begin
            bus.st_valid = st_pat[s];
            bus.st_data  = 64'hA5A5_0000_0000_0000 | 64'(s + 1);
            bus.st_be    = 8'(s + 1);
            if (st_pat[s]) begin
                exp_data = bus.st_data;
                exp_be   = bus.st_be;
            end
            tick();
            chk1("st_valid_out", bus.rvv_valid_out, st_pat[s]);
            chk1("st_req_low",   bus.rvv_req_out, 1'b0);
            if (st_pat[s]) begin
                chk32("st_addr",  bus.rvv_addr_out, st_addr[beat]);
                chk64("st_data",  bus.rvv_data_out, exp_data);
                chk64("st_be",    64'(bus.rvv_be_out), 64'(exp_be));
                chk1 ("st_start", bus.rvv_start_out, beat == 0);
                beat++;
            end
            chk1("st_ready_seq", bus.st_ready, beat < 4);
        end
        tick();
        chk1("st_no_extra", bus.rvv_valid_out, 1'b0);
        bus.st_valid = 1'b0;
        bus.rvv_done_ld = 1'b1;
        tick();
        bus.rvv_done_ld = 1'b0;
        chk1("st_wrong_done", bus.cmd_done, 1'b0);
        bus.rvv_done_st = 1'b1;
        tick();
        bus.rvv_done_st = 1'b0;
        chk1("st_cmd_done",  bus.cmd_done, 1'b1);
        chk1("st_cmd_ready", bus.cmd_ready, 1'b1);
        tick();

        // Address wrap past 2^32
        send_cmd(1'b0, 32'hFFFF_FFF8, 32'd4, 9'd4);
        tick();
        bus.cmd_valid = 1'b0;
        chk32("wrap_a0", bus.rvv_addr_out, 32'hFFFF_FFF8);
        tick();
        chk32("wrap_a1", bus.rvv_addr_out, 32'hFFFF_FFFC);
        tick();
        chk32("wrap_a2", bus.rvv_addr_out, 32'h0000_0000);
        tick();
        chk32("wrap_a3", bus.rvv_addr_out, 32'h0000_0004);
        chk1 ("wrap_req", bus.rvv_req_out, 1'b1);
        tick();
        chk1 ("wrap_ready_out", bus.rvv_ready_out, 1'b1);
        bus.rvv_done_ld = 1'b1;
        tick();
        bus.rvv_done_ld = 1'b0;
        chk1 ("wrap_done", bus.cmd_done, 1'b1);
        tick();

        // Reset during beat 3 of a 10-beat load
        send_cmd(1'b0, 32'h0000_3000, 32'd4, 9'd10);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk32("mrst_beat3", bus.rvv_addr_out, 32'h0000_300C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1 ("mrst_req",       bus.rvv_req_out, 1'b0);
        chk32("mrst_addr",      bus.rvv_addr_out, 32'h0);
        chk1 ("mrst_cmd_ready", bus.cmd_ready, 1'b1);
        chk1 ("mrst_done",      bus.cmd_done, 1'b0);
        bus.rvv_done_ld = 1'b1;
        tick();
        bus.rvv_done_ld = 1'b0;
        chk1 ("mrst_late_done", bus.cmd_done, 1'b0);
        chk1 ("mrst_req_idle",  bus.rvv_req_out, 1'b0);
        tick();
        chk1 ("mrst_late_done2", bus.cmd_done, 1'b0);

        // Misaligned base
        send_cmd(1'b0, 32'h0000_1002, 32'd4, 9'd2);
        tick();
        bus.cmd_valid = 1'b0;
`ifdef VLSU_ALIGN_CHECK_EN
        chk1("mis_err",       bus.cmd_err, 1'b1);
        chk1("mis_req",       bus.rvv_req_out, 1'b0);
        chk1("mis_cmd_ready", bus.cmd_ready, 1'b1);
        tick();
        chk1("mis_err_once",  bus.cmd_err, 1'b0);
        chk1("mis_req2",      bus.rvv_req_out, 1'b0);
        chk1("mis_done",      bus.cmd_done, 1'b0);
`else
        chk1 ("mis_err",  bus.cmd_err, 1'b0);
        chk1 ("mis_req0", bus.rvv_req_out, 1'b1);
        chk32("mis_a0",   bus.rvv_addr_out, 32'h0000_1002);
        tick();
        chk32("mis_a1",   bus.rvv_addr_out, 32'h0000_1006);
        tick();
        chk1 ("mis_ready_out", bus.rvv_ready_out, 1'b1);
        bus.rvv_done_ld = 1'b1;
        tick();
        bus.rvv_done_ld = 1'b0;
        chk1 ("mis_done", bus.cmd_done, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
